// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration chain loader: FSM encoding,
// error flag positions and frame sizing helper.
package cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int ERR_UNDERRUN = 0;
    localparam int ERR_TIMEOUT  = 1;
    localparam int ERR_W        = 2;

    // Number of parallel words needed to carry len bits (ceil division).
    function automatic int words_in_frame(input int len, input int word_w);
        return (len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// One-word holding buffer feeding a shift register; emits one config bit per
// cycle LSB first and reports when the shifter starves.
module cfg_word_serializer
    import cfg_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              bit_out,
    output logic              first,
    output logic              last,
    output logic              word_ready,
    output logic              underrun
);

    localparam int WB_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] buf_q;
    logic              buf_full;
    logic [WORD_W-1:0] sr_q;
    logic [WB_W-1:0]   wbits_q;
    logic [LEN_W-1:0]  bits_left;
    logic [LEN_W-1:0]  words_left;
    logic              active_q;
    logic              first_q;

    logic              accept;
    logic              word_end;
    logic              more;
    logic              fill_load;
    logic              reload;
    logic              load;
    logic [LEN_W-1:0]  bits_after;
    logic [WB_W-1:0]   load_bits;

    assign s_ready    = en && !buf_full && (words_left != '0);
    assign accept     = s_valid && s_ready;
    assign word_end   = active_q && (wbits_q == WB_W'(1));
    assign more       = (bits_left != LEN_W'(1));
    assign fill_load  = en && !active_q && buf_full;
    assign reload     = word_end && more && buf_full;
    assign underrun   = word_end && more && !buf_full;
    assign load       = fill_load || reload;
    assign last       = active_q && (bits_left == LEN_W'(1));
    assign word_ready = buf_full;
    assign bit_out    = active_q && sr_q[0];
    assign first      = active_q && first_q;

    // The final word of a frame only carries the remaining bit count.
    assign bits_after = active_q ? (bits_left - LEN_W'(1)) : bits_left;
    assign load_bits  = (bits_after >= LEN_W'(WORD_W)) ? WB_W'(WORD_W) : WB_W'(bits_after);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q      <= '0;
            buf_full   <= 1'b0;
            sr_q       <= '0;
            wbits_q    <= '0;
            bits_left  <= '0;
            words_left <= '0;
            active_q   <= 1'b0;
            first_q    <= 1'b0;
        end else if (start) begin
            buf_full   <= 1'b0;
            active_q   <= 1'b0;
            first_q    <= 1'b0;
            bits_left  <= len;
            words_left <= LEN_W'(words_in_frame(int'(len), WORD_W));
        end else begin
            if (accept) begin
                buf_q      <= s_data;
                buf_full   <= 1'b1;
                words_left <= words_left - LEN_W'(1);
            end
            if (load) begin
                sr_q     <= buf_q;
                wbits_q  <= load_bits;
                active_q <= 1'b1;
                buf_full <= 1'b0;
            end else if (active_q) begin
                sr_q    <= sr_q >> 1;
                wbits_q <= wbits_q - WB_W'(1);
                if (wbits_q == WB_W'(1)) begin
                    active_q <= 1'b0;
                end
            end
            if (active_q) begin
                bits_left <= bits_left - LEN_W'(1);
            end
            first_q <= fill_load;
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// Frame-level controller for the CLB config chain: command handshake, FSM,
// return-strobe latency measurement and fault flags.
module cfg_chain_loader
    import cfg_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              crst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              chain_start,
    output logic              chain_bit,
    input  logic              chain_ret_start,
    output logic              busy,
    output logic              done,
    output logic              err_underrun,
    output logic              err_timeout,
    output logic [LEN_W-1:0]  ret_lat,
    output logic [1:0]        fsm_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; ready never depends combinationally on valid.

    state_t             state_q, state_nxt;
    logic               ready_en_q;
    logic               done_q, done_nxt;
    logic [ERR_W-1:0]   err_q;
    logic [LEN_W-1:0]   ret_lat_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               frozen_q;

    logic               cmd_hs;
    logic               counting;
    logic               ret_hit;
    logic               timed_out;
    logic               clr_err, set_under, set_to, ser_start, ser_en;
    logic               ser_first, ser_last, ser_word_ready, ser_underrun, ser_bit;

    assign cmd_ready    = (state_q == ST_IDLE) && ready_en_q;
    assign cmd_hs       = cmd_valid && cmd_ready;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign err_underrun = err_q[ERR_UNDERRUN];
    assign err_timeout  = err_q[ERR_TIMEOUT];
    assign ret_lat      = ret_lat_q;
    assign fsm_state    = state_q;
    assign chain_bit    = ser_bit;
    assign chain_start  = ser_first;
    assign ser_en       = (state_q == ST_FILL) || (state_q == ST_SHIFT);

    // Latency runs from the chain_start cycle until the first return strobe.
    assign counting  = (state_q == ST_SHIFT) || (state_q == ST_DRAIN);
    assign ret_hit   = counting && chain_ret_start && !frozen_q;
    assign timed_out = (state_q == ST_DRAIN) && !frozen_q && !ret_hit &&
                       (cnt_q >= LEN_W'(TIMEOUT));

    cfg_word_serializer #(
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) u_ser (
        .clk        (clk),
        .rst        (crst),
        .start      (ser_start),
        .len        (cmd_len),
        .en         (ser_en),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .bit_out    (ser_bit),
        .first      (ser_first),
        .last       (ser_last),
        .word_ready (ser_word_ready),
        .underrun   (ser_underrun)
    );

    always_ff @(posedge clk or posedge crst) begin
        if (crst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        done_nxt  = 1'b0;
        clr_err   = 1'b0;
        set_under = 1'b0;
        set_to    = 1'b0;
        ser_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    clr_err = 1'b1;
                    if (cmd_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        ser_start = 1'b1;
                        state_nxt = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (ser_word_ready) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ser_underrun) begin
                    set_under = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (ser_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (frozen_q || ret_hit) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (timed_out) begin
                    set_to    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge crst) begin
        if (crst) begin
            ready_en_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
            ret_lat_q  <= '0;
            cnt_q      <= '0;
            frozen_q   <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            done_q     <= done_nxt;
            if (clr_err) begin
                err_q <= '0;
            end
            if (set_under) begin
                err_q[ERR_UNDERRUN] <= 1'b1;
            end
            if (set_to) begin
                err_q[ERR_TIMEOUT] <= 1'b1;
            end
            if (cmd_hs) begin
                ret_lat_q <= '0;
                frozen_q  <= 1'b0;
            end
            if ((state_q == ST_FILL) && (state_nxt == ST_SHIFT)) begin
                cnt_q <= '0;
            end else if (counting && (cnt_q != '1)) begin
                cnt_q <= cnt_q + LEN_W'(1);
            end
            if (ret_hit) begin
                ret_lat_q <= cnt_q;
                frozen_q  <= 1'b1;
            end
            if (set_to) begin
                ret_lat_q <= LEN_W'(TIMEOUT);
            end
        end
    end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Upstream feeder for the per-CLB configuration shift chain.
- Accepts a frame command plus a stream of parallel configuration words and serializes them gaplessly onto the chain head (start strobe + bit).
- Watches the chain tail for the returning start strobe, measures chain latency, and flags underrun or timeout faults.
- Sits between the fabric config master (bus/JTAG bridge) and the first config_block in the tile chain.

Parameters:
- WORD_W, 32, width of each parallel config word.
- LEN_W, 16, width of frame bit count and latency counter.
- TIMEOUT, 4096, maximum cycles from chain_start to returned start before an error is flagged.

Ports:
- clk  in  1  global clock.
- crst  in  1  config reset; asynchronous, active-high.
- cmd_valid  in  1  frame command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_len  in  LEN_W  total frame bits; sampled on cmd handshake.
- s_valid  in  1  data word valid.
- s_ready  out  1  holding buffer empty and frame in progress.
- s_data  in  WORD_W  config word; serialized LSB first.
- chain_start  out  1  one-cycle strobe coincident with the first frame bit.
- chain_bit  out  1  serial config bit to chain head.
- chain_ret_start  in  1  start strobe emerging from chain tail.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err_underrun  out  1  sticky until next cmd: buffer empty when shifter needed a word.
- err_timeout  out  1  sticky until next cmd: no return strobe within TIMEOUT.
- ret_lat  out  LEN_W  cycles from chain_start to chain_ret_start; valid at done.

Behaviour:
- Reset (async): all outputs 0, including cmd_ready; buffer and shifter cleared; state IDLE. cmd_ready rises the first cycle after reset deasserts. Reset mid-frame abandons the frame silently, with no done.
- States: IDLE, FILL, SHIFT, DRAIN.
- IDLE:
  - cmd handshake with cmd_len=0: done pulses the next cycle, no words consumed, no chain_start, errors cleared, ret_lat=0.
  - Otherwise: latch len, clear errors, go to FILL.
- FILL:
  - s_ready=1 until the first word is buffered.
  - On the cycle after the first word lands in the buffer, it moves to the shifter and state goes to SHIFT.
- SHIFT:
  - Bit 0 of the word is driven on chain_bit with chain_start=1 (first word only). One bit per cycle after that, no gaps.
  - Holding buffer (1 word) refills while shifting; s_ready = buffer empty AND words remaining to accept > 0.
  - At the last bit of a word, the buffered word loads into the shifter with zero bubble.
  - Final word: only len - WORD_W*(n-1) bits are shifted; upper bits are ignored.
  - If the shifter needs a word and the buffer is empty: err_underrun=1, chain_bit=0, state goes to IDLE, and done pulses. Words that arrive later are not accepted (s_ready=0 in IDLE).
- Latency counter:
  - Starts at 0 on the chain_start cycle and increments every cycle.
  - The first chain_ret_start after chain_start freezes ret_lat. This can happen during SHIFT if the chain is shorter than the frame; any further return strobes are ignored.
- After the last bit: chain_bit=0 and state goes to DRAIN.
- DRAIN: wait for the frozen latency, then pulse done next cycle and return to IDLE. If the counter reaches TIMEOUT first: err_timeout=1, ret_lat=TIMEOUT, done, IDLE.
- A chain_ret_start on the same cycle as the counter reaching TIMEOUT counts as success.
- Count arithmetic: counters saturate at all-ones and never wrap.
- chain_ret_start in IDLE is ignored.

Decomposition:
- Shared package cfg_pkg holds:
  - state encoding for IDLE/FILL/SHIFT/DRAIN;
  - error bit positions;
  - a function for words-in-frame = ceil(len/WORD_W).
- One sub-module, cfg_word_serializer: holding buffer, shift register, per-word bit counter, and need_word/underrun outputs. The FSM and latency monitor stay in the top level.

Test Plan:
- Happy path, chain emulated as a 40-cycle delay line: cmd_len=40, WORD_W=32, words 0xDEADBEEF, 0x000000A5 always valid.
  - chain_start exactly once with bit 1.
  - 40 bits LSB-first: EF...DE, then A5 low byte.
  - No gaps; s_data bits 8..31 of word 2 never appear.
  - ret_lat=40, done one pulse, no errors.
- Zero length: cmd_len=0 → done on the next cycle, s_ready never high, chain_start never high.
- Underrun: cmd_len=64, second word withheld → err_underrun at bit 32, done pulses, busy falls, chain_bit=0.
- Timeout: TIMEOUT=100, chain_ret_start tied low → err_timeout, ret_lat=100, done.
- Short chain: cmd_len=96 with a 10-cycle chain → ret_lat=10 captured mid-SHIFT, done after bit 96, no timeout.
- Reset mid-frame: crst asserted at bit 20 of 64 → all outputs 0 immediately, no done. A new cmd after release then completes normally.
